layer_ctrl: RTL

- Per-layer sequencer directly downstream of the model controller. Consumes its one-cycle ln_start pulse and walks one transformer layer through its sub-stages: LN1, QKV, per-head attention, projection, LN2, linear1, linear2.
- Returns a one-cycle linear2_done pulse to the model controller when the layer completes.
- Maintains layer_idx and head_idx for weight/KV addressing, and flags protocol and timeout errors.

---
 rtl/layer_ctrl_pkg.sv | 43 ++++
 rtl/layer_ctrl_watchdog.sv | 35 +++
 rtl/layer_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/layer_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the per-layer sequencer.
package layer_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LN1,
    QKV,
    ATTN,
    PROJ,
    LN2,
    LIN1,
    LIN2
  } state_e;

  localparam int NUM_STAGE     = 7;
  localparam int DEF_NUM_LAYER = 12;
  localparam int DEF_NUM_HEAD  = 12;
  localparam int DEF_TIMEOUT   = 65535;

  typedef logic [NUM_STAGE-1:0] stageVec_t;

  // Index counters never shrink below one bit, even for a single layer/head.
  function automatic int clogMin1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic stageVec_t stageOneHot(input state_e s);
    stageVec_t oh;
    oh = '0;
    case (s)
      LN1:     oh[0] = 1'b1;
      QKV:     oh[1] = 1'b1;
      ATTN:    oh[2] = 1'b1;
      PROJ:    oh[3] = 1'b1;
      LN2:     oh[4] = 1'b1;
      LIN1:    oh[5] = 1'b1;
      LIN2:    oh[6] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/layer_ctrl_watchdog.sv
// Saturating per-stage wait counter; flags once a stage has waited TIMEOUT cycles.
module stage_watchdog #(
  parameter int  TIMEOUT = 65535,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds cycles already waited; this cycle without a done completes TIMEOUT.
  assign timeout_o = enable_i && !clear_i && (cnt_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/layer_ctrl.sv
// Walks one transformer layer through its sub-stages, tracking layer/head indices
// and flagging protocol and watchdog errors.
module layer_ctrl
  import layer_ctrl_pkg::*;
#(
  parameter int  NUM_LAYER = DEF_NUM_LAYER,
  parameter int  NUM_HEAD  = DEF_NUM_HEAD,
  parameter int  TIMEOUT   = DEF_TIMEOUT,
  localparam int LW        = clogMin1(NUM_LAYER),
  localparam int HW        = clogMin1(NUM_HEAD)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          model_start,
  input  logic          ln_start,
  output logic          linear2_done,
  output logic          busy,
  output logic          ln1_start,
  input  logic          ln1_done,
  output logic          qkv_start,
  input  logic          qkv_done,
  output logic          attn_start,
  input  logic          attn_done,
  output logic          proj_start,
  input  logic          proj_done,
  output logic          ln2_start,
  input  logic          ln2_done,
  output logic          lin1_start,
  input  logic          lin1_done,
  output logic          lin2_start,
  input  logic          lin2_done,
  output logic [LW-1:0] layer_idx,
  output logic [HW-1:0] head_idx,
  output logic          last_layer,
  output logic          err_unexpected,
  output logic          err_timeout
);

  state_e    state_q, state_d;
  stageVec_t start_q, start_d;
  stageVec_t doneVec, curMask;
  logic          linear2Done_q, linear2Done_d;
  logic [LW-1:0] layerIdx_q, layerIdx_d;
  logic [HW-1:0] headIdx_q, headIdx_d;
  logic          errUnexp_q, errUnexp_d;
  logic          errTimeout_q, errTimeout_d;
  logic curDone, otherDone, startActive, advance, idle;
  logic lastHead, lastLayer, clearErr, protoErr, wdTimeout;

  assign doneVec     = {lin2_done, lin1_done, ln2_done, proj_done, attn_done, qkv_done, ln1_done};
  assign curMask     = stageOneHot(state_q);
  assign curDone     = |(doneVec & curMask);
  assign otherDone   = |(doneVec & ~curMask);
  assign startActive = |start_q;
  // A done coinciding with its own start pulse cannot belong to that start.
  assign advance     = curDone && !startActive;
  assign idle        = (state_q == IDLE);
  assign lastHead    = (headIdx_q == HW'(NUM_HEAD - 1));
  assign lastLayer   = (layerIdx_q == LW'(NUM_LAYER - 1));
  assign clearErr    = idle && model_start;
  assign protoErr    = otherDone || (curDone && startActive) || (!idle && (ln_start || model_start));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      start_q       <= '0;
      linear2Done_q <= 1'b0;
      layerIdx_q    <= '0;
      headIdx_q     <= '0;
      errUnexp_q    <= 1'b0;
      errTimeout_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      linear2Done_q <= linear2Done_d;
      layerIdx_q    <= layerIdx_d;
      headIdx_q     <= headIdx_d;
      errUnexp_q    <= errUnexp_d;
      errTimeout_q  <= errTimeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ln_start) state_d = LN1;
      LN1:     if (advance) state_d = QKV;
      QKV:     if (advance) state_d = ATTN;
      ATTN:    if (advance && lastHead) state_d = PROJ;
      PROJ:    if (advance) state_d = LN2;
      LN2:     if (advance) state_d = LIN1;
      LIN1:    if (advance) state_d = LIN2;
      LIN2:    if (advance) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_d       = '0;
    linear2Done_d = 1'b0;
    layerIdx_d    = layerIdx_q;
    headIdx_d     = headIdx_q;
    if (clearErr) begin
      layerIdx_d = '0;
    end
    // Entering a stage, or finishing a non-final head, fires the stage start.
    if ((state_d != state_q) || ((state_q == ATTN) && advance)) begin
      start_d = stageOneHot(state_d);
    end
    if ((state_q == ATTN) && advance) begin
      headIdx_d = lastHead ? '0 : headIdx_q + 1'b1;
    end
    if ((state_q == LIN2) && advance) begin
      linear2Done_d = 1'b1;
      layerIdx_d    = lastLayer ? '0 : layerIdx_q + 1'b1;
    end
    errUnexp_d   = (clearErr ? 1'b0 : errUnexp_q) | protoErr;
    errTimeout_d = (clearErr ? 1'b0 : errTimeout_q) | wdTimeout;
  end

  stage_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWatchdog (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clear_i  (|start_d),
    .enable_i (!idle && !advance),
    .timeout_o(wdTimeout)
  );

  assign {lin2_start, lin1_start, ln2_start, proj_start, attn_start, qkv_start, ln1_start} = start_q;
  assign linear2_done   = linear2Done_q;
  assign busy           = !idle;
  assign layer_idx      = layerIdx_q;
  assign head_idx       = headIdx_q;
  assign last_layer     = lastLayer;
  assign err_unexpected = errUnexp_q;
  assign err_timeout    = errTimeout_q;

endmodule
